// File: rtl/jump_state_counter.sv
// jump_state_counter
//
// Game-state controller plus a pair of frame-gated jump counters.
//
// The state machine walks IDLE -> LOAD -> PLAY -> HALT -> IDLE, driven by
// keyboard keycodes, and advances on every Clk. LOAD lasts exactly one cycle
// and is reported on loadplat, which gives one platform-load pulse per game
// start.
//
// The counters update only on Clk edges where frame_tick is high:
//   counting  - 7-bit frame counter; increments when jump_enable is high.
//               It wraps silently.
//   counting2 - 2-bit slow counter; increments on every tick whose pre-edge
//               counting[5] is set. It does not depend on jump_enable.
//
// Parameters:
//   KEY_START   - keycode that starts a game (IDLE -> LOAD)
//   KEY_HALT    - keycode that halts play (PLAY -> HALT)
//   KEY_RESTART - keycode that returns from halt (HALT -> IDLE)
//
// Ports:
//   Clk         in   system clock; all state changes on its rising edge
//   Reset       in   synchronous, active-low reset
//   frame_tick  in   one-Clk pulse per video frame; gates both counters
//   keycode     in   [7:0] current keycode; 0 means no key
//   jump_reset  in   synchronous clear of both counters, active-high
//   jump_enable in   count enable for counting
//   counting    out  [6:0] frame counter
//   counting2   out  [1:0] slow counter
//   outstate    out  [2:0] registered game state code
//   loadplat    out  platform-load strobe, high while in LOAD
module jump_state_counter #(
    parameter logic [7:0] KEY_START   = 8'd40,
    parameter logic [7:0] KEY_HALT    = 8'd41,
    parameter logic [7:0] KEY_RESTART = 8'd21
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic       jump_reset,
    input  logic       jump_enable,
    output logic [6:0] counting,
    output logic [1:0] counting2,
    output logic [2:0] outstate,
    output logic       loadplat
);

    typedef enum logic [2:0] {
        Idle = 3'b000,
        Play = 3'b001,
        Halt = 3'b010,
        Load = 3'b011
    } stateT;

    stateT       stateReg;
    stateT       stateNext;
    logic [6:0]  countReg;
    logic [1:0]  slowReg;

    // State register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            stateReg <= Idle;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic; unused codes fall back to Idle
    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            Idle: if (keycode == KEY_START)   stateNext = Load;
            Load:                             stateNext = Play;
            Play: if (keycode == KEY_HALT)    stateNext = Halt;
            Halt: if (keycode == KEY_RESTART) stateNext = Idle;
            default:                          stateNext = Idle;
        endcase
    end

    // Jump counters. Both branches read pre-edge values, so a tick that bumps
    // counting past bit 5 does not also bump counting2 on the same edge.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            countReg <= 7'd0;
            slowReg  <= 2'd0;
        end else if (frame_tick) begin
            if (jump_reset) begin
                countReg <= 7'd0;
                slowReg  <= 2'd0;
            end else begin
                if (jump_enable) begin
                    countReg <= countReg + 7'd1;
                end
                if (countReg[5]) begin
                    slowReg <= slowReg + 2'd1;
                end
            end
        end
    end

    assign outstate  = stateReg;
    assign loadplat  = (stateReg == Load);
    assign counting  = countReg;
    assign counting2 = slowReg;

endmodule

// File: tb/tb_jump_state_counter.sv
// Bench for jump_state_counter: directed stimulus pushes hand-computed
// expectations into a queue, and a negedge monitor pops and compares them.
module tb_jump_state_counter;

    logic       Clk;
    logic       Reset;
    logic       frame_tick;
    logic [7:0] keycode;
    logic       jump_reset;
    logic       jump_enable;
    logic [6:0] counting;
    logic [1:0] counting2;
    logic [2:0] outstate;
    logic       loadplat;

    jump_state_counter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .keycode     (keycode),
        .jump_reset  (jump_reset),
        .jump_enable (jump_enable),
        .counting    (counting),
        .counting2   (counting2),
        .outstate    (outstate),
        .loadplat    (loadplat)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic       lp;
        logic [6:0] c;
        logic [1:0] c2;
    } expT;

    expT q[$];
    int  nAssert = 0;
    int  nFail   = 0;

    function automatic void expectOut(input string n, input logic [2:0] st, input logic lp,
                                      input logic [6:0] c, input logic [1:0] c2);
        expT e;
        e.name = n;
        e.st   = st;
        e.lp   = lp;
        e.c    = c;
        e.c2   = c2;
        q.push_back(e);
    endfunction

    // Monitor: outputs are stable at the falling edge
    always @(negedge Clk) begin
        while (q.size() > 0) begin
            expT e;
            e = q.pop_front();
            nAssert++;
            if ({outstate, loadplat, counting, counting2} !== {e.st, e.lp, e.c, e.c2}) begin
                nFail++;
                $display("FAIL %s: got state=%b loadplat=%b counting=%0d counting2=%0d, want state=%b loadplat=%b counting=%0d counting2=%0d",
                         e.name, outstate, loadplat, counting, counting2, e.st, e.lp, e.c, e.c2);
            end
        end
    end

    // One Clk edge; inputs written afterwards land before the next edge
    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    int tickList[12] = '{1, 32, 33, 35, 40, 64, 65, 96, 127, 128, 129, 130};
    int slowList[12] = '{0, 0, 1, 3, 0, 0, 0, 0, 3, 0, 0, 0};

    initial begin
        // Reset overrides every other input
        Reset = 1'b0; frame_tick = 1'b1; jump_enable = 1'b1; jump_reset = 1'b0;
        keycode = 8'd40;
        cyc(); expectOut("reset1", 3'b000, 1'b0, 7'd0, 2'd0);
        cyc(); expectOut("reset2", 3'b000, 1'b0, 7'd0, 2'd0);
        Reset = 1'b1; frame_tick = 1'b0; jump_enable = 1'b0; keycode = 8'd0;
        cyc(); expectOut("idle_hold", 3'b000, 1'b0, 7'd0, 2'd0);

        // Start held for five cycles: one LOAD pulse, then PLAY is sticky
        keycode = 8'd40;
        cyc(); expectOut("start_load", 3'b011, 1'b1, 7'd0, 2'd0);
        cyc(); expectOut("start_play", 3'b001, 1'b0, 7'd0, 2'd0);
        cyc(); expectOut("play_hold3", 3'b001, 1'b0, 7'd0, 2'd0);
        cyc(); expectOut("play_hold4", 3'b001, 1'b0, 7'd0, 2'd0);
        cyc(); expectOut("play_hold5", 3'b001, 1'b0, 7'd0, 2'd0);

        // Halt, start ignored in halt, restart to idle
        keycode = 8'd41;
        cyc(); expectOut("halt", 3'b010, 1'b0, 7'd0, 2'd0);
        keycode = 8'd40;
        cyc(); expectOut("halt_ignores_start", 3'b010, 1'b0, 7'd0, 2'd0);
        keycode = 8'd21;
        cyc(); expectOut("restart_idle", 3'b000, 1'b0, 7'd0, 2'd0);

        // LOAD leaves after one cycle even with the halt key present
        keycode = 8'd40;
        cyc(); expectOut("load2", 3'b011, 1'b1, 7'd0, 2'd0);
        keycode = 8'd41;
        cyc(); expectOut("load_ignores_key", 3'b001, 1'b0, 7'd0, 2'd0);
        cyc(); expectOut("halt2", 3'b010, 1'b0, 7'd0, 2'd0);
        keycode = 8'd21;
        cyc(); expectOut("restart2", 3'b000, 1'b0, 7'd0, 2'd0);
        keycode = 8'd0;

        // 130 ticks, one every fourth Clk
        jump_enable = 1'b1;
        for (int t = 1; t <= 130; t++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            for (int k = 0; k < 12; k++) begin
                if (tickList[k] == t) begin
                    expectOut($sformatf("tick%0d", t), 3'b000, 1'b0, 7'(t % 128),
                              2'(slowList[k]));
                end
            end
            cyc();
            if (t == 3) expectOut("no_tick_hold", 3'b000, 1'b0, 7'd3, 2'd0);
            cyc(); cyc();
        end

        // Tick with enable low holds counting
        jump_enable = 1'b0; frame_tick = 1'b1;
        cyc(); expectOut("enable_low", 3'b000, 1'b0, 7'd2, 2'd0);

        // Advance 2 -> 50; pre-edge values 32..49 give 18 slow increments -> 2
        jump_enable = 1'b1;
        repeat (48) cyc();
        expectOut("count50", 3'b000, 1'b0, 7'd50, 2'd2);

        // jump_reset without a tick does nothing, with a tick clears both
        frame_tick = 1'b0; jump_reset = 1'b1;
        cyc(); expectOut("jreset_no_tick", 3'b000, 1'b0, 7'd50, 2'd2);
        frame_tick = 1'b1;
        cyc(); expectOut("jreset_tick", 3'b000, 1'b0, 7'd0, 2'd0);
        jump_reset = 1'b0;

        // Count to 17, then enter PLAY
        repeat (17) cyc();
        frame_tick = 1'b0; keycode = 8'd40;
        cyc(); expectOut("load3", 3'b011, 1'b1, 7'd17, 2'd0);
        keycode = 8'd0;
        cyc(); expectOut("play17", 3'b001, 1'b0, 7'd17, 2'd0);

        // Reset mid-cycle must not act before the edge
        Reset = 1'b0; frame_tick = 1'b1;
        expectOut("reset_not_async", 3'b001, 1'b0, 7'd17, 2'd0);
        cyc(); expectOut("reset_in_play", 3'b000, 1'b0, 7'd0, 2'd0);
        Reset = 1'b1; frame_tick = 1'b0; jump_enable = 1'b0;
        cyc(); expectOut("after_reset_play", 3'b000, 1'b0, 7'd0, 2'd0);

        // Reset during LOAD aborts with no further pulse
        keycode = 8'd40;
        cyc(); expectOut("load4", 3'b011, 1'b1, 7'd0, 2'd0);
        Reset = 1'b0; keycode = 8'd0;
        cyc(); expectOut("reset_in_load", 3'b000, 1'b0, 7'd0, 2'd0);
        Reset = 1'b1;
        cyc(); expectOut("after_reset_load", 3'b000, 1'b0, 7'd0, 2'd0);

        @(negedge Clk);
        #1;
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
            nFail += q.size();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
